pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning PC and address width in bits.
REQ-002 The block SHALL have parameter STEP, default 1, meaning the sequential increment added on INC.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (>=2).
REQ-004 The block SHALL have parameter RESET_VEC, default 0, meaning the PC value after reset.
REQ-005 The block SHALL have port Clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port Reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-007 The block SHALL have port LD_PC, input, 1, meaning a load enable; the PC holds when it is low.
REQ-008 The block SHALL have port PCMUX, input, 3, meaning next-PC select: 0 INC, 1 BUS, 2 AC, 3 RET; 4-7 reserved.
REQ-009 The block SHALL have port CALL, input, 1, meaning push the return address on a BUS/AC load.
REQ-010 The block SHALL have port from_bus, input, WIDTH, meaning the bus target.
REQ-011 The block SHALL have port from_AC, input, WIDTH, meaning the address-calculator target.
REQ-012 The block SHALL have port clr_err, input, 1, meaning clear all sticky error flags.
REQ-013 The block SHALL have port PC_out, output, WIDTH, meaning the current PC, driven directly from a register.
REQ-014 The block SHALL have port ras_empty, output, 1, meaning the stack holds 0 entries.
REQ-015 The block SHALL have port ras_full, output, 1, meaning the stack holds RAS_DEPTH entries.
REQ-016 The block SHALL have port err, output, 3, meaning sticky flags {illegal_sel, underflow, overflow} (bit 2 to bit 0).

Function
REQ-017 When LD_PC=1 and PCMUX=INC, the block SHALL load PC_out+STEP modulo 2^WIDTH; FFFF+1 wraps to 0000.
REQ-018 When LD_PC=1 and PCMUX=BUS or AC, the block SHALL load from_bus or from_AC respectively on the next edge.
REQ-019 When LD_PC=1, PCMUX is BUS or AC, and CALL=1, the block SHALL push PC_out+STEP (wrapped) onto the stack in the same cycle as the load.
REQ-020 The block SHALL ignore CALL when PCMUX is INC, RET or reserved, or when LD_PC=0.
REQ-021 A push while full SHALL discard the oldest entry, keep the count at RAS_DEPTH, store the new entry and set err[0].
REQ-022 When LD_PC=1 and PCMUX=RET with the stack non-empty, the block SHALL load the top entry into the PC and pop it.
REQ-023 When LD_PC=1 and PCMUX=RET with the stack empty, the block SHALL hold the PC, leave the stack unchanged and set err[1].
REQ-024 When LD_PC=1 and PCMUX is reserved, the block SHALL hold the PC and stack and set err[2]; it SHALL never drive a high-impedance value.
REQ-025 Each err bit SHALL remain set until clr_err=1.
REQ-026 When clr_err=1 and a new error occur in the same cycle, the new error SHALL win and its err bit SHALL be 1.
REQ-027 ras_empty and ras_full SHALL be registered-state decodes of the entry count, valid in the same cycle as the count.
REQ-028 All loads SHALL have a latency of one edge; PC_out SHALL have no combinational path from any input.

Reset
REQ-029 While Reset_n=0, asynchronously: PC_out=RESET_VEC, stack count=0, ras_empty=1, ras_full=0, err=000.
REQ-030 A reset mid-sequence SHALL discard all stack contents; the first RET after reset SHALL underflow.
REQ-031 The stack storage array need not be reset, but it SHALL never be observable while the count is 0.

Structure
REQ-032 Shared package pc_seq_pkg SHALL hold the PCMUX encoding enum (PC_INC, PC_BUS, PC_AC, PC_RET) and the err bit-index constants.
REQ-033 The stack SHALL be sub-module pc_ras, a circular buffer with a top pointer and a count of $clog2(RAS_DEPTH+1) bits, exposing push, pop, top, empty, full and overflow.
REQ-034 The block SHALL contain no latches, and the next-PC mux SHALL be a complete case with a default.

Verification
REQ-035 Scenario: reset, then LD_PC=1 with INC for 3 cycles -> PC_out 0000, 0001, 0002, 0003.
REQ-036 Scenario: PC=FFFF, INC -> PC=0000 with err=000.
REQ-037 Scenario: PC=0010; BUS with from_bus=0200 and CALL=1; then RET -> PC 0200 then 0011; ras_empty returns to 1.
REQ-038 Scenario: 5 nested calls, RAS_DEPTH=4 -> err[0]=1 and ras_full=1; then 4 RETs return the last 4 addresses in LIFO order, and a 5th RET holds the PC and sets err[1].
REQ-039 Scenario: PCMUX=5 with LD_PC=1 -> PC unchanged and err[2]=1; then clr_err -> err=000.
REQ-040 Scenario: Reset_n pulsed low between edges with 2 entries stacked -> PC_out=RESET_VEC immediately, ras_empty=1, and the next RET sets err[1].

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared encodings for the program-counter sequencer
package pc_seq_pkg;

   typedef enum logic [2:0] {
      PC_INC = 3'd0,
      PC_BUS = 3'd1,
      PC_AC  = 3'd2,
      PC_RET = 3'd3
   } pcmux_e;

   localparam int ERR_W         = 3;
   localparam int ERR_OVERFLOW  = 0;
   localparam int ERR_UNDERFLOW = 1;
   localparam int ERR_ILLEGAL   = 2;

   function automatic logic is_target_sel(input logic [2:0] sel);
      return (sel == PC_BUS) || (sel == PC_AC);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push while full overwrites the oldest entry
module pc_ras #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             overflow
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    top_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    prev_ptr;
   logic [CW-1:0]    count;

   assign wr_ptr   = (top_ptr == PTR_LAST) ? '0 : top_ptr + PW'(1);
   assign prev_ptr = (top_ptr == '0) ? PTR_LAST : top_ptr - PW'(1);

   assign empty    = (count == '0);
   assign full     = (count == CNT_MAX);
   assign overflow = push && full;

   // When full, wr_ptr lands on the oldest slot, so the overwrite discards it naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_ptr <= '0;
         count   <= '0;
      end else if (push) begin
         top_ptr <= wr_ptr;
         if (!full) begin
            count <= count + CW'(1);
         end
      end else if (pop && !empty) begin
         top_ptr <= prev_ptr;
         count   <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Stale storage is masked so nothing leaks out while the stack is empty.
   assign top = empty ? '0 : mem[top_ptr];

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with return-address stack and sticky error flags
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter int               STEP      = 1,
   parameter int               RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             LD_PC,
   input  logic [2:0]       PCMUX,
   input  logic             CALL,
   input  logic [WIDTH-1:0] from_bus,
   input  logic [WIDTH-1:0] from_AC,
   input  logic             clr_err,
   output logic [WIDTH-1:0] PC_out,
   output logic             ras_empty,
   output logic             ras_full,
   output logic [ERR_W-1:0] err
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] ras_top;
   logic             ras_push;
   logic             ras_pop;
   logic             ras_ovf;
   logic [ERR_W-1:0] err_set;

   assign pc_inc = PC_out + STEP_W;

   always_comb begin
      pc_next = PC_out;
      ras_pop = 1'b0;
      err_set = '0;
      if (LD_PC) begin
         case (PCMUX)
            PC_INC: pc_next = pc_inc;
            PC_BUS: pc_next = from_bus;
            PC_AC:  pc_next = from_AC;
            PC_RET: begin
               if (!ras_empty) begin
                  pc_next = ras_top;
                  ras_pop = 1'b1;
               end else begin
                  err_set[ERR_UNDERFLOW] = 1'b1;
               end
            end
            default: err_set[ERR_ILLEGAL] = 1'b1;
         endcase
      end
      err_set[ERR_OVERFLOW] = ras_ovf;
   end

   assign ras_push = LD_PC && CALL && is_target_sel(PCMUX);

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .push     (ras_push),
      .pop      (ras_pop),
      .din      (pc_inc),
      .top      (ras_top),
      .empty    (ras_empty),
      .full     (ras_full),
      .overflow (ras_ovf)
   );

   // Clear applies to previously latched bits only; errors raised this cycle still land.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         PC_out <= RESET_VEC;
         err    <= '0;
      end else begin
         PC_out <= pc_next;
         err    <= (clr_err ? '0 : err) | err_set;
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - scoreboard bench for pc_seq with directed vectors
module tb_pc_seq;

   typedef struct packed {
      logic [15:0] pc;
      logic        empty;
      logic        full;
      logic [2:0]  err;
   } exp_t;

   logic        Clk;
   logic        Reset_n;
   logic        LD_PC;
   logic [2:0]  PCMUX;
   logic        CALL;
   logic [15:0] from_bus;
   logic [15:0] from_AC;
   logic        clr_err;
   logic [15:0] PC_out;
   logic        ras_empty;
   logic        ras_full;
   logic [2:0]  err;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   vec   = 0;

   pc_seq dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .LD_PC     (LD_PC),
      .PCMUX     (PCMUX),
      .CALL      (CALL),
      .from_bus  (from_bus),
      .from_AC   (from_AC),
      .clr_err   (clr_err),
      .PC_out    (PC_out),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .err       (err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input exp_t want);
      exp_t got;
      got = '{pc: PC_out, empty: ras_empty, full: ras_full, err: err};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got pc=%h empty=%b full=%b err=%b, want pc=%h empty=%b full=%b err=%b",
                  name, got.pc, got.empty, got.full, got.err,
                  want.pc, want.empty, want.full, want.err);
      end
   endtask

   task automatic step(input logic ld, input logic [2:0] mux, input logic call,
                       input logic [15:0] bus, input logic [15:0] ac, input logic clr,
                       input logic [15:0] pc, input logic e, input logic f, input logic [2:0] er);
      @(negedge Clk);
      LD_PC    = ld;
      PCMUX    = mux;
      CALL     = call;
      from_bus = bus;
      from_AC  = ac;
      clr_err  = clr;
      exp_q.push_back('{pc: pc, empty: e, full: f, err: er});
   endtask

   // Monitor: each edge that has a queued expectation is checked 1 time unit later.
   initial begin
      forever begin
         @(posedge Clk);
         #1;
         if (exp_q.size() > 0) begin
            vec++;
            check($sformatf("vec%0d", vec), exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n  = 1'b0;
      LD_PC    = 1'b0;
      PCMUX    = 3'd0;
      CALL     = 1'b0;
      from_bus = '0;
      from_AC  = '0;
      clr_err  = 1'b0;
      #2;
      check("reset_state", '{pc: 16'h0000, empty: 1'b1, full: 1'b0, err: 3'b000});
      @(negedge Clk);
      Reset_n = 1'b1;

      //    ld   mux   call bus       ac        clr   pc        e     f     err
      step(1'b1, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0, 3'b000);
      step(1'b1, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b0, 3'b000);
      step(1'b1, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 3'b000);
      step(1'b1, 3'd1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 3'b000);
      step(1'b1, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 3'b000);
      step(1'b1, 3'd1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0010, 1'b1, 1'b0, 3'b000);
      step(1'b1, 3'd1, 1'b1, 16'h0200, 16'h0000, 1'b0, 16'h0200, 1'b0, 1'b0, 3'b000);
      step(1'b1, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0011, 1'b1, 1'b0, 3'b000);
      // five nested calls into a 4-deep stack
      step(1'b1, 3'd1, 1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b0, 3'b000);
      step(1'b1, 3'd2, 1'b1, 16'h0000, 16'h0200, 1'b0, 16'h0200, 1'b0, 1'b0, 3'b000);
      step(1'b1, 3'd1, 1'b1, 16'h0300, 16'h0000, 1'b0, 16'h0300, 1'b0, 1'b0, 3'b000);
      step(1'b1, 3'd2, 1'b1, 16'h0000, 16'h0400, 1'b0, 16'h0400, 1'b0, 1'b1, 3'b000);
      step(1'b1, 3'd1, 1'b1, 16'h0500, 16'h0000, 1'b0, 16'h0500, 1'b0, 1'b1, 3'b001);
      step(1'b1, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0401, 1'b0, 1'b0, 3'b001);
      step(1'b1, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0301, 1'b0, 1'b0, 3'b001);
      step(1'b1, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0201, 1'b0, 1'b0, 3'b001);
      step(1'b1, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0101, 1'b1, 1'b0, 3'b001);
      step(1'b1, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0101, 1'b1, 1'b0, 3'b011);
      step(1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0101, 1'b1, 1'b0, 3'b000);
      // CALL ignored on INC and when LD_PC is low
      step(1'b1, 3'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0102, 1'b1, 1'b0, 3'b000);
      step(1'b0, 3'd1, 1'b1, 16'h0900, 16'h0000, 1'b0, 16'h0102, 1'b1, 1'b0, 3'b000);
      // reserved selects and clear-versus-new-error priority
      step(1'b1, 3'd5, 1'b1, 16'h0900, 16'h0000, 1'b0, 16'h0102, 1'b1, 1'b0, 3'b100);
      step(1'b1, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0102, 1'b1, 1'b0, 3'b010);
      step(1'b1, 3'd7, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0102, 1'b1, 1'b0, 3'b110);
      step(1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0102, 1'b1, 1'b0, 3'b000);
      step(1'b1, 3'd1, 1'b1, 16'h0A00, 16'h0000, 1'b0, 16'h0A00, 1'b0, 1'b0, 3'b000);
      step(1'b1, 3'd2, 1'b1, 16'h0000, 16'h0B00, 1'b0, 16'h0B00, 1'b0, 1'b0, 3'b000);

      @(posedge Clk);
      #3;
      LD_PC   = 1'b0;
      CALL    = 1'b0;
      Reset_n = 1'b0;
      #1;
      check("async_reset", '{pc: 16'h0000, empty: 1'b1, full: 1'b0, err: 3'b000});
      @(negedge Clk);
      Reset_n = 1'b1;

      step(1'b1, 3'd3, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 3'b010);
      step(1'b1, 3'd2, 1'b0, 16'h0000, 16'h1234, 1'b0, 16'h1234, 1'b1, 1'b0, 3'b010);

      @(posedge Clk);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
